// File: rtl/fc_pkg.sv
// Shared definitions for fully connected layers and their parameter stores.
//   state_t    : load/serve state of the parameter store
//   w_depth    : number of weights in a layer (inputs per neuron * neurons)
//   addr_width : address width for a memory of a given depth (at least 1 bit)
package fc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD_W,
        LOAD_B,
        READY
    } state_t;

    function automatic int w_depth(input int input_size, input int output_size);
        return input_size * output_size;
    endfunction

    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fc_param_store_if.sv
// Bus between a parameter store and its users: the byte load stream from the
// host/loader plus the weight and bias read ports used by the FC layer.
//   master : host/loader and layer side (drives load beats and read requests)
//   slave  : parameter store side (returns ready, status and read data)
interface fc_param_store_if
    import fc_pkg::*;
#(
    parameter int INPUT_SIZE    = 784,
    parameter int OUTPUT_SIZE   = 512,
    parameter int WEIGHTS_WIDTH = 8,
    parameter int BIAS_WIDTH    = 32
);

    localparam int W_AW = addr_width(w_depth(INPUT_SIZE, OUTPUT_SIZE));
    localparam int B_AW = addr_width(OUTPUT_SIZE);

    logic                             load_start;
    logic                             load_valid;
    logic                             load_ready;
    logic signed [WEIGHTS_WIDTH-1:0]  load_data;
    logic                             load_done;
    logic                             loaded;
    logic                             w_read_en;
    logic        [W_AW-1:0]           w_read_addr;
    logic signed [WEIGHTS_WIDTH-1:0]  w_read_data;
    logic                             b_read_en;
    logic        [B_AW-1:0]           b_read_addr;
    logic signed [BIAS_WIDTH-1:0]     b_read_data;
    logic                             rd_err;

    modport master (
        output load_start, load_valid, load_data,
        output w_read_en, w_read_addr, b_read_en, b_read_addr,
        input  load_ready, load_done, loaded,
        input  w_read_data, b_read_data, rd_err
    );

    modport slave (
        input  load_start, load_valid, load_data,
        input  w_read_en, w_read_addr, b_read_en, b_read_addr,
        output load_ready, load_done, loaded,
        output w_read_data, b_read_data, rd_err
    );

endinterface

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with registered data.
// No reset on the array or the read register so it maps onto block RAM.
//   clk   : clock
//   we    : write enable, waddr/wdata : write address/data
//   re    : read enable,  raddr       : read address
//   rdata : read data, updated one edge after re, held while re is low
module sdp_ram
    import fc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW   = addr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/fc_param_store.sv
// Parameter store for one FC layer. Loads all weights then all biases from a
// byte stream, then serves 1-cycle registered weight and bias reads.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : load stream, load status, weight/bias read ports, rd_err
module fc_param_store
    import fc_pkg::*;
#(
    parameter int INPUT_SIZE    = 784,
    parameter int OUTPUT_SIZE   = 512,
    parameter int WEIGHTS_WIDTH = 8,
    parameter int BIAS_WIDTH    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    fc_param_store_if.slave   bus
);

    localparam int W_DEPTH        = w_depth(INPUT_SIZE, OUTPUT_SIZE);
    localparam int BEATS_PER_BIAS = BIAS_WIDTH / WEIGHTS_WIDTH;
    localparam int W_AW           = addr_width(W_DEPTH);
    localparam int B_AW           = addr_width(OUTPUT_SIZE);
    localparam int CNT_W          = addr_width(BEATS_PER_BIAS);

    localparam logic [W_AW-1:0]  W_LAST    = W_AW'(W_DEPTH - 1);
    localparam logic [B_AW-1:0]  B_LAST    = B_AW'(OUTPUT_SIZE - 1);
    localparam logic [CNT_W-1:0] BYTE_LAST = CNT_W'(BEATS_PER_BIAS - 1);

    state_t                  state;
    logic [W_AW-1:0]         wptr;
    logic [B_AW-1:0]         bptr;
    logic [CNT_W-1:0]        byte_cnt;
    logic [BIAS_WIDTH-1:0]   bias_acc;
    logic [BIAS_WIDTH-1:0]   bias_word;
    logic                    load_ready_q;
    logic                    load_done_q;
    logic                    loaded_q;
    logic                    accept;
    logic                    byte_last;
    logic                    w_we;
    logic                    b_we;
    logic                    w_valid;
    logic                    b_valid;
    logic                    w_ok_q;
    logic                    b_ok_q;
    logic                    rd_err_q;
    logic [WEIGHTS_WIDTH-1:0] w_q;
    logic [BIAS_WIDTH-1:0]    b_q;

    // load_start wins over a beat presented in the same cycle.
    assign accept    = bus.load_valid && load_ready_q && !bus.load_start;
    assign byte_last = (byte_cnt == BYTE_LAST);
    assign w_we      = accept && (state == LOAD_W);
    assign b_we      = accept && (state == LOAD_B) && byte_last;

    // Little-endian assembly: the incoming beat lands in the lane selected by
    // byte_cnt, so the final beat completes the word without an extra cycle.
    always_comb begin
        bias_word = bias_acc;
        bias_word[int'(byte_cnt) * WEIGHTS_WIDTH +: WEIGHTS_WIDTH] = bus.load_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            wptr         <= '0;
            bptr         <= '0;
            byte_cnt     <= '0;
            bias_acc     <= '0;
            load_ready_q <= 1'b0;
            load_done_q  <= 1'b0;
            loaded_q     <= 1'b0;
        end else begin
            load_done_q <= 1'b0;
            if (bus.load_start) begin
                state        <= LOAD_W;
                wptr         <= '0;
                bptr         <= '0;
                byte_cnt     <= '0;
                loaded_q     <= 1'b0;
                load_ready_q <= 1'b1;
            end else begin
                case (state)
                    LOAD_W: begin
                        if (accept) begin
                            if (wptr == W_LAST) begin
                                wptr  <= '0;
                                state <= LOAD_B;
                            end else begin
                                wptr <= wptr + 1'b1;
                            end
                        end
                    end
                    LOAD_B: begin
                        if (accept) begin
                            bias_acc <= bias_word;
                            if (byte_last) begin
                                byte_cnt <= '0;
                                if (bptr == B_LAST) begin
                                    bptr         <= '0;
                                    state        <= READY;
                                    load_ready_q <= 1'b0;
                                    load_done_q  <= 1'b1;
                                    loaded_q     <= 1'b1;
                                end else begin
                                    bptr <= bptr + 1'b1;
                                end
                            end else begin
                                byte_cnt <= byte_cnt + 1'b1;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign w_valid = loaded_q && (int'(bus.w_read_addr) < W_DEPTH);
    assign b_valid = loaded_q && (int'(bus.b_read_addr) < OUTPUT_SIZE);

    // The RAMs are only read on valid requests, so their output registers
    // hold the last good word; w_ok_q/b_ok_q remember whether the most recent
    // request was valid and gate the output to zero otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_ok_q   <= 1'b0;
            b_ok_q   <= 1'b0;
            rd_err_q <= 1'b0;
        end else begin
            if (bus.w_read_en) begin
                w_ok_q <= w_valid;
            end
            if (bus.b_read_en) begin
                b_ok_q <= b_valid;
            end
            if (bus.load_start) begin
                rd_err_q <= 1'b0;
            end else if ((bus.w_read_en && !w_valid) || (bus.b_read_en && !b_valid)) begin
                rd_err_q <= 1'b1;
            end
        end
    end

    sdp_ram #(
        .WIDTH (WEIGHTS_WIDTH),
        .DEPTH (W_DEPTH)
    ) u_wmem (
        .clk   (clk),
        .we    (w_we),
        .waddr (wptr),
        .wdata (bus.load_data),
        .re    (bus.w_read_en && w_valid),
        .raddr (bus.w_read_addr),
        .rdata (w_q)
    );

    sdp_ram #(
        .WIDTH (BIAS_WIDTH),
        .DEPTH (OUTPUT_SIZE)
    ) u_bmem (
        .clk   (clk),
        .we    (b_we),
        .waddr (bptr),
        .wdata (bias_word),
        .re    (bus.b_read_en && b_valid),
        .raddr (bus.b_read_addr),
        .rdata (b_q)
    );

    assign bus.load_ready  = load_ready_q;
    assign bus.load_done   = load_done_q;
    assign bus.loaded      = loaded_q;
    assign bus.rd_err      = rd_err_q;
    assign bus.w_read_data = w_ok_q ? w_q : '0;
    assign bus.b_read_data = b_ok_q ? b_q : '0;

endmodule

// File: tb/tb_fc_param_store.sv
// Self-checking bench for fc_param_store. Geometry is 3 inputs x 3 neurons
// (9 weights, 3 biases, 12 bias beats) so that out-of-range weight and bias
// addresses fit in the address ports.
module tb_fc_param_store;
    import fc_pkg::*;

    localparam int IS     = 3;
    localparam int OS     = 3;
    localparam int WW     = 8;
    localparam int BW     = 32;
    localparam int WD     = w_depth(IS, OS);
    localparam int WA     = addr_width(WD);
    localparam int BA     = addr_width(OS);
    localparam int BEATS  = BW / WW;
    localparam int NBEATS = WD + OS * BEATS;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fc_param_store_if #(.INPUT_SIZE(IS), .OUTPUT_SIZE(OS), .WEIGHTS_WIDTH(WW), .BIAS_WIDTH(BW)) bus ();

    fc_param_store #(.INPUT_SIZE(IS), .OUTPUT_SIZE(OS), .WEIGHTS_WIDTH(WW), .BIAS_WIDTH(BW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: memory images, status flags and last returned words.
    logic [WW-1:0] ref_w [WD];
    logic [BW-1:0] ref_b [OS];
    bit            ref_loaded;
    bit            ref_err;
    logic [WW-1:0] ref_wq;
    logic [BW-1:0] ref_bq;
    logic [WW-1:0] stream [$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void build_stream(input bit plan);
        stream.delete();
        for (int i = 0; i < NBEATS; i++) stream.push_back(WW'($urandom));
        if (plan) begin
            for (int i = 0; i < WD; i++) stream[i] = WW'(i + 1);
            stream[WD + 0] = 8'h10; stream[WD + 1] = 8'h00; stream[WD + 2] = 8'h00; stream[WD + 3] = 8'h00;
            stream[WD + 4] = 8'hF0; stream[WD + 5] = 8'hFF; stream[WD + 6] = 8'hFF; stream[WD + 7] = 8'hFF;
        end
    endfunction

    // A completed load: first WD bytes are weights, then each group of BEATS
    // bytes is one bias, least significant byte first.
    function automatic void model_commit();
        for (int i = 0; i < WD; i++) ref_w[i] = stream[i];
        for (int j = 0; j < OS; j++)
            for (int k = 0; k < BEATS; k++)
                ref_b[j][k*WW +: WW] = stream[WD + j*BEATS + k];
        ref_loaded = 1'b1;
    endfunction

    task automatic pulse_start();
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
        ref_loaded = 1'b0;
        ref_err    = 1'b0;
    endtask

    // Presents stream[0..count-1]; with gaps, load_valid drops randomly.
    task automatic drive_stream(input int count, input bit gaps, output int early_done, output bit timeout);
        int idx = 0;
        int budget = 0;
        logic ready_now;
        early_done = 0;
        timeout = 1'b0;
        while (idx < count && !timeout) begin
            bus.load_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.load_data  = stream[idx];
            ready_now      = bus.load_ready;
            tick();
            if (bus.load_valid && ready_now) idx++;
            if (bus.load_done && idx < NBEATS) early_done++;
            budget++;
            if (budget > 20 * NBEATS) timeout = 1'b1;
        end
        bus.load_valid = 1'b0;
    endtask

    // Issues one read cycle on either/both ports and updates the model.
    task automatic issue_read(input bit we, input int wa, input bit be, input int ba);
        bus.w_read_en   = we;
        bus.w_read_addr = WA'(wa);
        bus.b_read_en   = be;
        bus.b_read_addr = BA'(ba);
        tick();
        bus.w_read_en = 1'b0;
        bus.b_read_en = 1'b0;
        if (we) begin
            if (ref_loaded && wa < WD) ref_wq = ref_w[wa];
            else begin ref_wq = '0; ref_err = 1'b1; end
        end
        if (be) begin
            if (ref_loaded && ba < OS) ref_bq = ref_b[ba];
            else begin ref_bq = '0; ref_err = 1'b1; end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.load_start = 0; bus.load_valid = 0; bus.load_data = '0;
        bus.w_read_en = 0; bus.w_read_addr = '0; bus.b_read_en = 0; bus.b_read_addr = '0;
        ref_loaded = 0; ref_err = 0; ref_wq = '0; ref_bq = '0;
        #12;
        vectors++;
        if ({bus.load_ready, bus.load_done, bus.loaded, bus.rd_err, bus.w_read_data, bus.b_read_data} !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: got rdy=%b done=%b loaded=%b err=%b w=%h b=%h, need all 0",
                     bus.load_ready, bus.load_done, bus.loaded, bus.rd_err, bus.w_read_data, bus.b_read_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus.load_valid = 1'b1;
        tick(); tick();
        bus.load_valid = 1'b0;
        vectors++;
        if (bus.load_ready !== 1'b0 || bus.loaded !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL idle_after_reset: got rdy=%b loaded=%b, need 0 0", bus.load_ready, bus.loaded);
        end
    endtask

    task automatic test_full_load();
        int early; bit to;
        pulse_start();
        build_stream(1'b1);
        drive_stream(NBEATS, 1'b0, early, to);
        model_commit();
        vectors++;
        if (to || early != 0 || bus.load_done !== 1'b1 || bus.loaded !== 1'b1 || bus.load_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL full_load_end: got timeout=%0d early_done=%0d done=%b loaded=%b rdy=%b, need 0 0 1 1 0",
                     to, early, bus.load_done, bus.loaded, bus.load_ready);
        end
        tick();
        vectors++;
        if (bus.load_done !== 1'b0 || bus.loaded !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL done_pulse_width: got done=%b loaded=%b, need 0 1", bus.load_done, bus.loaded);
        end
        for (int i = 0; i < WD; i++) begin
            int a = (i + 4) % WD;
            issue_read(1'b1, a, 1'b1, a % OS);
            vectors++;
            if (bus.w_read_data !== ref_wq || bus.b_read_data !== ref_bq || bus.rd_err !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL full_load_read a=%0d: got w=%h b=%h err=%b, need w=%h b=%h err=0",
                         a, bus.w_read_data, bus.b_read_data, bus.rd_err, ref_wq, ref_bq);
            end
        end
    endtask

    task automatic test_read_timing();
        issue_read(1'b1, 5, 1'b0, 0);
        vectors++;
        if (bus.w_read_data !== 8'h06) begin
            miscompares++;
            $display("[TB] FAIL w_read_addr5: got %h, need 06", bus.w_read_data);
        end
        bus.w_read_addr = WA'(2);
        tick(); tick();
        vectors++;
        if (bus.w_read_data !== 8'h06) begin
            miscompares++;
            $display("[TB] FAIL w_read_hold: got %h, need 06", bus.w_read_data);
        end
        issue_read(1'b0, 0, 1'b1, 1);
        vectors++;
        if (bus.b_read_data !== 32'hFFFF_FFF0 || bus.w_read_data !== 8'h06) begin
            miscompares++;
            $display("[TB] FAIL b_read_addr1: got b=%h w=%h, need b=fffffff0 w=06", bus.b_read_data, bus.w_read_data);
        end
        issue_read(1'b0, 0, 1'b1, 0);
        vectors++;
        if (bus.b_read_data !== 32'h0000_0010) begin
            miscompares++;
            $display("[TB] FAIL b_read_addr0: got %h, need 00000010", bus.b_read_data);
        end
    endtask

    task automatic test_gaps();
        int early; bit to;
        pulse_start();
        build_stream(1'b0);
        drive_stream(NBEATS, 1'b1, early, to);
        model_commit();
        vectors++;
        if (to || early != 0 || bus.load_done !== 1'b1 || bus.loaded !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL gaps_load_end: got timeout=%0d early_done=%0d done=%b loaded=%b, need 0 0 1 1",
                     to, early, bus.load_done, bus.loaded);
        end
        for (int n = 0; n < 16; n++) begin
            int wa = $urandom_range(0, WD - 1);
            int ba = $urandom_range(0, OS - 1);
            bit we = 1'($urandom_range(0, 1));
            bit be = 1'($urandom_range(0, 1));
            issue_read(we, wa, be, ba);
            vectors++;
            if (bus.w_read_data !== ref_wq || bus.b_read_data !== ref_bq || bus.rd_err !== ref_err) begin
                miscompares++;
                $display("[TB] FAIL gaps_read wa=%0d ba=%0d: got w=%h b=%h err=%b, need w=%h b=%h err=%b",
                         wa, ba, bus.w_read_data, bus.b_read_data, bus.rd_err, ref_wq, ref_bq, ref_err);
            end
        end
    endtask

    task automatic test_invalid();
        int early; bit to;
        pulse_start();
        issue_read(1'b1, 1, 1'b0, 0);
        vectors++;
        if (bus.w_read_data !== '0 || bus.rd_err !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL read_before_load: got w=%h err=%b, need 00 1", bus.w_read_data, bus.rd_err);
        end
        build_stream(1'b0);
        drive_stream(NBEATS, 1'b0, early, to);
        model_commit();
        issue_read(1'b1, 0, 1'b1, 2);
        issue_read(1'b1, 9, 1'b0, 0);
        vectors++;
        if (to || bus.w_read_data !== '0 || bus.rd_err !== 1'b1 || bus.b_read_data !== ref_bq) begin
            miscompares++;
            $display("[TB] FAIL w_addr_out_of_range: got timeout=%0d w=%h err=%b b=%h, need 0 00 1 %h",
                     to, bus.w_read_data, bus.rd_err, bus.b_read_data, ref_bq);
        end
        issue_read(1'b0, 0, 1'b1, 3);
        vectors++;
        if (bus.b_read_data !== '0 || bus.rd_err !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL b_addr_out_of_range: got b=%h err=%b, need 0 1", bus.b_read_data, bus.rd_err);
        end
        pulse_start();
        vectors++;
        if (bus.rd_err !== 1'b0 || bus.loaded !== 1'b0 || bus.load_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL start_clears_err: got err=%b loaded=%b rdy=%b, need 0 0 1",
                     bus.rd_err, bus.loaded, bus.load_ready);
        end
    endtask

    task automatic test_restart();
        int early; bit to;
        build_stream(1'b0);
        drive_stream(3, 1'b0, early, to);
        bus.load_start = 1'b1;
        bus.load_valid = 1'b1;
        bus.load_data  = 8'hAA;
        tick();
        bus.load_start = 1'b0;
        bus.load_valid = 1'b0;
        ref_loaded = 1'b0;
        vectors++;
        if (bus.loaded !== 1'b0 || bus.load_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL restart_state: got loaded=%b rdy=%b, need 0 1", bus.loaded, bus.load_ready);
        end
        build_stream(1'b0);
        drive_stream(NBEATS, 1'b0, early, to);
        model_commit();
        issue_read(1'b1, 0, 1'b1, 0);
        vectors++;
        if (to || bus.w_read_data !== stream[0] || bus.b_read_data !== ref_bq) begin
            miscompares++;
            $display("[TB] FAIL restart_addr0: got timeout=%0d w=%h b=%h, need 0 %h %h",
                     to, bus.w_read_data, bus.b_read_data, stream[0], ref_bq);
        end
        for (int a = WD - 1; a > 0; a--) begin
            issue_read(1'b1, a, 1'b1, a % OS);
            vectors++;
            if (bus.w_read_data !== ref_wq || bus.b_read_data !== ref_bq) begin
                miscompares++;
                $display("[TB] FAIL restart_read a=%0d: got w=%h b=%h, need w=%h b=%h",
                         a, bus.w_read_data, bus.b_read_data, ref_wq, ref_bq);
            end
        end
    endtask

    task automatic test_async_reset();
        int early; bit to;
        bit stayed_idle = 1'b1;
        pulse_start();
        build_stream(1'b0);
        drive_stream(WD + 2, 1'b0, early, to);
        issue_read(1'b1, 0, 1'b0, 0);
        #3;
        rst_n = 1'b0;
        #1;
        ref_loaded = 0; ref_err = 0; ref_wq = '0; ref_bq = '0;
        vectors++;
        if ({bus.load_ready, bus.load_done, bus.loaded, bus.rd_err, bus.w_read_data, bus.b_read_data} !== '0) begin
            miscompares++;
            $display("[TB] FAIL async_reset_outputs: got rdy=%b done=%b loaded=%b err=%b w=%h b=%h, need all 0",
                     bus.load_ready, bus.load_done, bus.loaded, bus.rd_err, bus.w_read_data, bus.b_read_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus.load_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.load_ready !== 1'b0 || bus.loaded !== 1'b0) stayed_idle = 1'b0;
        end
        bus.load_valid = 1'b0;
        vectors++;
        if (!stayed_idle) begin
            miscompares++;
            $display("[TB] FAIL idle_until_start: got rdy=%b loaded=%b, need 0 0", bus.load_ready, bus.loaded);
        end
        pulse_start();
        build_stream(1'b0);
        drive_stream(NBEATS, 1'b0, early, to);
        model_commit();
        for (int n = 0; n < 8; n++) begin
            int wa = $urandom_range(0, WD - 1);
            int ba = $urandom_range(0, OS - 1);
            issue_read(1'b1, wa, 1'b1, ba);
            vectors++;
            if (to || bus.w_read_data !== ref_wq || bus.b_read_data !== ref_bq || bus.rd_err !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL reload_read wa=%0d ba=%0d: got timeout=%0d w=%h b=%h err=%b, need 0 %h %h 0",
                         wa, ba, to, bus.w_read_data, bus.b_read_data, bus.rd_err, ref_wq, ref_bq);
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_read_timing();
        test_gaps();
        test_invalid();
        test_restart();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fc_param_store.md
Name: fc_param_store

Overview:
- Parameter memory that sits on the far side of a fully connected layer's weight and bias RAM read interfaces.
- Accepts a byte stream from the host or loader (valid/ready): all weights first, then all biases.
- Once loaded, it answers the layer's w_read_en/addr and b_read_en/addr requests with 1-cycle registered read data.
- One instance per FC layer; parameters match the layer it serves.

Parameters:
- INPUT_SIZE, 784: inputs per neuron.
- OUTPUT_SIZE, 512: neurons; also the bias count.
- WEIGHTS_WIDTH, 8: weight width; also the load-stream beat width.
- BIAS_WIDTH, 32: bias width; must be a multiple of WEIGHTS_WIDTH.
- Derived W_DEPTH = INPUT_SIZE*OUTPUT_SIZE.
- Derived BEATS_PER_BIAS = BIAS_WIDTH/WEIGHTS_WIDTH.

Ports:
- clk  in  1  single clock, all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- load_start  in  1  pulse: begin a full parameter load.
- load_valid  in  1  load beat valid.
- load_ready  out  1  store can accept a beat.
- load_data  in  WEIGHTS_WIDTH  signed load beat.
- load_done  out  1  one-cycle pulse when the last bias is written.
- loaded  out  1  contents valid; held until the next load_start or reset.
- w_read_en  in  1  weight read request.
- w_read_addr  in  $clog2(W_DEPTH)  weight address (node*INPUT_SIZE+idx).
- w_read_data  out  WEIGHTS_WIDTH  signed weight.
- b_read_en  in  1  bias read request.
- b_read_addr  in  $clog2(OUTPUT_SIZE)  bias address.
- b_read_data  out  BIAS_WIDTH  signed bias.
- rd_err  out  1  sticky flag: invalid read occurred.

Behaviour:
- Reset (rst_n low, async): state IDLE, load_ready=0, load_done=0, loaded=0, w_read_data=0, b_read_data=0, rd_err=0, all pointers 0. Memory contents are not cleared.
- States: IDLE, LOAD_W, LOAD_B, READY.
- load_start is honoured in any state and takes priority: pointers and byte counter go to 0, loaded=0, rd_err=0, next state LOAD_W. A beat presented in the same cycle is not accepted.
- load_ready=1 only in LOAD_W and LOAD_B. A beat is accepted when load_valid && load_ready.
- LOAD_W: on each accepted beat, wmem[wptr] <= load_data and wptr++. On the beat where wptr==W_DEPTH-1: wptr=0, go to LOAD_B.
- LOAD_B: beats assemble little-endian, first beat = bits [WEIGHTS_WIDTH-1:0]. On beat BEATS_PER_BIAS-1 the assembled word goes to bmem[bptr] and bptr++.
- LOAD_B end: after the last beat of bptr==OUTPUT_SIZE-1, go to READY. load_done pulses for exactly 1 cycle and loaded=1 from the same edge.
- READY: load_ready=0; only load_start leaves this state.
- Weight read: when w_read_en is sampled high at edge E, w_read_data = wmem[w_read_addr] after E. That is 1-cycle latency, valid before the requester's sample two edges after it presents the address.
- Read data holds its last value while read_en is low.
- Bias read: same timing and rules via b_read_en, b_read_addr and bmem.
- Invalid read: a read while loaded=0, or with address >= depth, returns 0 and sets rd_err. rd_err stays set until load_start or reset.
- Weight and bias reads are independent and may occur in the same cycle.
- Reads during LOAD_* are invalid (loaded=0). Loading never stalls on reads.
- Reset mid-load: returns to IDLE with loaded=0. A full reload is required; there is no partial resume.
- Memories are simple dual-port (1W/1R each) and must infer block RAM. There is no read-during-write hazard, because reads are only valid in READY.

Decomposition:
- Shared package fc_pkg holds:
  - the state_t enum (IDLE, LOAD_W, LOAD_B, READY);
  - helper functions for W_DEPTH and address widths, so that FC layers and the store agree.
- One natural sub-module: sdp_ram, a parameterised width/depth simple dual-port RAM with a registered read-data port. It is instantiated twice (weights, biases).
- The out-of-range/unloaded zeroing mux stays in the top level.

Test Plan (INPUT_SIZE=4, OUTPUT_SIZE=2, so W_DEPTH=8, 8 bias beats):
- Full load:
  - Stimulus: load_start, then weight bytes 0x01..0x08, then bias bytes 10 00 00 00, F0 FF FF FF, with load_valid held high.
  - Expect load_done as a 1-cycle pulse after the 16th beat, then loaded=1 and load_ready=0.
- Read timing:
  - Stimulus: w_read_en=1, addr=5 at edge E.
  - Expect w_read_data=0x06 after E, held while en=0.
  - Stimulus: b_read addr=1.
  - Expect b_read_data=-16.
- Backpressure/gaps:
  - Stimulus: load_valid toggling 1,0,0,1...
  - Expect only valid beats to be stored; final contents identical to the full-load case.
- Invalid reads:
  - Stimulus: w_read before load completes.
  - Expect data 0 and rd_err=1.
  - Stimulus: in READY, w_read addr=9.
  - Expect data 0 and rd_err still set.
  - Stimulus: load_start.
  - Expect rd_err=0.
- Restart:
  - Stimulus: load_start asserted at beat 3 of a load.
  - Expect loaded=0 and pointers restarted; after a full new stream, addr 0 reads the new first byte.
- Async reset mid-load:
  - Stimulus: rst_n low mid-cycle during LOAD_B.
  - Expect all outputs 0 immediately and IDLE state; load_ready stays 0 until load_start.
